// File: rtl/typing_game_if.sv
// typing_game_if: bundles the keyboard, button, text and display signals of typing_game_ctrl.
// The master drives text, key_valid, key_code, btn_start and btn_pause, and reads Q, cur,
// err_cnt, sec_left, hit and miss. The slave (the controller) does the opposite.
interface typing_game_if #(parameter int N_CHARS = 200);
  logic [6*N_CHARS-1:0] text;
  logic key_valid;
  logic [5:0] key_code;
  logic btn_start;
  logic btn_pause;
  logic [2:0] Q;
  logic [9:0] cur;
  logic [7:0] err_cnt;
  logic [6:0] sec_left;
  logic hit;
  logic miss;
  modport master(output text, key_valid, key_code, btn_start, btn_pause,
                 input Q, cur, err_cnt, sec_left, hit, miss);
  modport slave(input text, key_valid, key_code, btn_start, btn_pause,
                output Q, cur, err_cnt, sec_left, hit, miss);
endinterface

// File: rtl/typing_game_ctrl.sv
// typing_game_ctrl: typing game sequencer. Ports: CLK, RST (sync, active-high), gi (slave side of typing_game_if).
module typing_game_ctrl #(
  parameter int N_CHARS    = 200,
  parameter int CLK_HZ     = 25_000_000,
  parameter int TIME_LIMIT = 60,
  parameter int MAX_ERR    = 10
) (
  input logic CLK,
  input logic RST,
  typing_game_if.slave gi
);
  localparam int PW = $clog2(CLK_HZ + 1);
  localparam logic [2:0] STOP = 3'd0, RUN = 3'd1, PAUSE = 3'd2, WIN = 3'd3, LOSE = 3'd4;
  logic [2:0] q, q_n;
  logic [9:0] cur, cur_n;
  logic [7:0] err, err_n;
  logic [6:0] sec, sec_n;
  logic [PW-1:0] psc, psc_n;
  logic hit, hit_n, miss, miss_n, bs_d, bp_d;
  logic start_rise, pause_rise, at_end, key_ok, key_bad, tick, err_lose, time_lose, run_step, restart;
  logic [5:0] ch;
  assign start_rise = gi.btn_start & ~bs_d;
  assign pause_rise = gi.btn_pause & ~bp_d;
  assign ch = (cur < 10'(N_CHARS)) ? gi.text[6*int'(cur) +: 6] : 6'd0;
  assign at_end = cur >= 10'(N_CHARS) || ch == 6'd0;
  assign key_ok = gi.key_valid && gi.key_code == ch;
  assign key_bad = gi.key_valid && gi.key_code != ch;
  assign tick = psc == PW'(CLK_HZ - 1);
  assign err_lose = key_bad && (err + 8'd1 == 8'(MAX_ERR));
  assign time_lose = tick && sec == 7'd1;
  // a RUN cycle that is not ending on the terminator applies keys and ticks
  assign run_step = q == RUN && !at_end;
  assign restart = (q == STOP || q == WIN || q == LOSE) && start_rise;
  always_ff @(posedge CLK)
    q <= RST ? STOP : q_n;
  always_comb begin
    q_n = STOP;
    case (q)
      STOP:     q_n = start_rise ? RUN : STOP;
      RUN:      q_n = at_end ? WIN : (err_lose || time_lose) ? LOSE : pause_rise ? PAUSE : RUN;
      PAUSE:    q_n = pause_rise ? RUN : PAUSE;
      WIN, LOSE: q_n = start_rise ? STOP : q;
      default:  q_n = STOP;
    endcase
  end
  always_comb begin
    cur_n = restart ? 10'd0 : (run_step && key_ok) ? cur + 10'd1 : cur;
    err_n = restart ? 8'd0 : (run_step && key_bad) ? err + 8'd1 : err;
    sec_n = restart ? 7'(TIME_LIMIT) : (run_step && tick && sec != 7'd0) ? sec - 7'd1 : sec;
    psc_n = restart ? '0 : run_step ? (tick ? '0 : psc + PW'(1)) : psc;
    hit_n = run_step && key_ok;
    miss_n = run_step && key_bad;
  end
  always_ff @(posedge CLK)
    if (RST) begin
      cur <= '0;
      err <= '0;
      sec <= 7'(TIME_LIMIT);
      psc <= '0;
      hit <= 1'b0;
      miss <= 1'b0;
      bs_d <= 1'b1;
      bp_d <= 1'b1;
    end else begin
      cur <= cur_n;
      err <= err_n;
      sec <= sec_n;
      psc <= psc_n;
      hit <= hit_n;
      miss <= miss_n;
      bs_d <= gi.btn_start;
      bp_d <= gi.btn_pause;
    end
  assign gi.Q = q;
  assign gi.cur = cur;
  assign gi.err_cnt = err;
  assign gi.sec_left = sec;
  assign gi.hit = hit;
  assign gi.miss = miss;
endmodule

// File: tb/tb_typing_game_ctrl.sv
// tb_typing_game_ctrl: directed self-checking bench for typing_game_ctrl.
module tb_typing_game_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int tests = 0;
  int fails = 0;
  typing_game_if #(.N_CHARS(4)) gi();
  typing_game_ctrl #(.N_CHARS(4), .CLK_HZ(10), .TIME_LIMIT(3), .MAX_ERR(3)) dut (
    .CLK(CLK),
    .RST(RST),
    .gi(gi)
  );
  always #5 CLK = ~CLK;
  task automatic step(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic key(input logic [5:0] c);
    gi.key_valid = 1'b1;
    gi.key_code = c;
    step();
    gi.key_valid = 1'b0;
  endtask
  task automatic restart;
    gi.btn_start = 1'b1;
    step();
    gi.btn_start = 1'b0;
    step();
    gi.btn_start = 1'b1;
    step();
    gi.btn_start = 1'b0;
  endtask
  initial begin
    gi.text = {6'd0, 6'd7, 6'd6, 6'd5};
    gi.key_valid = 1'b0;
    gi.key_code = 6'd0;
    gi.btn_start = 1'b0;
    gi.btn_pause = 1'b0;
    step(2);
    chk("rst_q", gi.Q, 0);
    chk("rst_cur", gi.cur, 0);
    chk("rst_err", gi.err_cnt, 0);
    chk("rst_sec", gi.sec_left, 3);
    chk("rst_hit", gi.hit, 0);
    chk("rst_miss", gi.miss, 0);
    RST = 1'b0;
    step();
    gi.btn_start = 1'b1;
    step();
    chk("start_q", gi.Q, 1);
    gi.btn_start = 1'b0;
    key(5);
    chk("k5_hit", gi.hit, 1);
    chk("k5_miss", gi.miss, 0);
    chk("k5_cur", gi.cur, 1);
    step();
    chk("k5_hit_end", gi.hit, 0);
    key(6);
    chk("k6_hit", gi.hit, 1);
    chk("k6_cur", gi.cur, 2);
    step();
    key(7);
    chk("k7_hit", gi.hit, 1);
    chk("k7_cur", gi.cur, 3);
    chk("k7_q", gi.Q, 1);
    step();
    chk("win_q", gi.Q, 3);
    chk("win_err", gi.err_cnt, 0);
    chk("win_sec", gi.sec_left, 3);
    chk("win_hit", gi.hit, 0);
    gi.btn_start = 1'b1;
    step();
    chk("win_stop_q", gi.Q, 0);
    chk("win_stop_cur", gi.cur, 0);
    gi.btn_start = 1'b0;
    step();
    gi.btn_start = 1'b1;
    step();
    chk("r2_q", gi.Q, 1);
    gi.btn_start = 1'b0;
    key(9);
    chk("m1_miss", gi.miss, 1);
    chk("m1_hit", gi.hit, 0);
    chk("m1_err", gi.err_cnt, 1);
    step();
    key(9);
    chk("m2_err", gi.err_cnt, 2);
    chk("m2_q", gi.Q, 1);
    step();
    key(9);
    chk("m3_err", gi.err_cnt, 3);
    chk("m3_miss", gi.miss, 1);
    chk("m3_q", gi.Q, 4);
    chk("m3_cur", gi.cur, 0);
    step();
    chk("lose_miss", gi.miss, 0);
    chk("lose_err", gi.err_cnt, 3);
    restart();
    chk("r3_q", gi.Q, 1);
    chk("r3_err", gi.err_cnt, 0);
    chk("r3_sec", gi.sec_left, 3);
    step(9);
    chk("t1_pre", gi.sec_left, 3);
    step();
    chk("t1", gi.sec_left, 2);
    step(10);
    chk("t2", gi.sec_left, 1);
    step(9);
    chk("t3_pre_sec", gi.sec_left, 1);
    chk("t3_pre_q", gi.Q, 1);
    step();
    chk("t3_sec", gi.sec_left, 0);
    chk("t3_q", gi.Q, 4);
    restart();
    step(4);
    gi.btn_pause = 1'b1;
    step();
    chk("pause_q", gi.Q, 2);
    gi.btn_pause = 1'b0;
    key(5);
    chk("pause_key_cur", gi.cur, 0);
    chk("pause_key_hit", gi.hit, 0);
    step(48);
    chk("pause_hold_q", gi.Q, 2);
    chk("pause_hold_sec", gi.sec_left, 3);
    gi.btn_pause = 1'b1;
    step();
    chk("resume_q", gi.Q, 1);
    gi.btn_pause = 1'b0;
    step(4);
    chk("resume_pre_tick", gi.sec_left, 3);
    step();
    chk("resume_tick", gi.sec_left, 2);
    step(10);
    chk("p_t2", gi.sec_left, 1);
    step(9);
    key(9);
    chk("tk_err", gi.err_cnt, 1);
    chk("tk_miss", gi.miss, 1);
    chk("tk_sec", gi.sec_left, 0);
    chk("tk_q", gi.Q, 4);
    gi.btn_start = 1'b1;
    step();
    chk("tk_stop_q", gi.Q, 0);
    chk("tk_stop_cur", gi.cur, 0);
    chk("tk_stop_err", gi.err_cnt, 0);
    chk("tk_stop_sec", gi.sec_left, 3);
    RST = 1'b1;
    step(2);
    RST = 1'b0;
    step(3);
    chk("held_start_q", gi.Q, 0);
    gi.btn_start = 1'b0;
    step();
    gi.btn_start = 1'b1;
    step();
    chk("press_q", gi.Q, 1);
    gi.btn_start = 1'b0;
    key(5);
    step();
    key(6);
    chk("pre_rst_cur", gi.cur, 2);
    gi.key_valid = 1'b1;
    gi.key_code = 6'd7;
    RST = 1'b1;
    step();
    chk("mid_rst_q", gi.Q, 0);
    chk("mid_rst_cur", gi.cur, 0);
    chk("mid_rst_err", gi.err_cnt, 0);
    chk("mid_rst_sec", gi.sec_left, 3);
    chk("mid_rst_hit", gi.hit, 0);
    chk("mid_rst_miss", gi.miss, 0);
    gi.key_valid = 1'b0;
    RST = 1'b0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
